// File: rtl/fft16_reorder_if.sv
// Stream bundle around the FFT output reorder buffer: butterfly pairs in, natural-order bins out.
interface fft16_reorder_if #(
    parameter int unsigned DW = 24
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] y0_real;
    logic [DW-1:0] y0_imag;
    logic [DW-1:0] y1_real;
    logic [DW-1:0] y1_imag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic [3:0]    out_index;
    logic          out_last;

    modport master (
        output in_valid, y0_real, y0_imag, y1_real, y1_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_index, out_last
    );

    modport slave (
        input  in_valid, y0_real, y0_imag, y1_real, y1_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_index, out_last
    );
endinterface

// File: rtl/fft16_reorder.sv
// Ping-pong reorder buffer: bit-reversed butterfly pairs in, bins 0..15 out in natural order.
// Optional FFT16_REORDER_SCALE_EN divides every output by 16 with rounding.
module fft16_reorder #(
    parameter int unsigned DW = 24
) (
    input logic            clk,
    input logic            rst,
    fft16_reorder_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_st_e;

    function automatic logic [3:0] bitrev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

`ifdef FFT16_REORDER_SCALE_EN
    // (x + 8) >>> 4 in DW+1 bits; the quotient always fits back into DW bits.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] x);
        logic [DW:0] sum;
        sum = {x[DW-1], x} + (DW+1)'(8);
        return {{3{sum[DW]}}, sum[DW:4]};
    endfunction
`else
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] x);
        return x;
    endfunction
`endif

    bank_st_e        state_q [2];
    bank_st_e        state_d [2];
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [DW-1:0]   out_real_q, out_real_d;
    logic [DW-1:0]   out_imag_q, out_imag_d;
    logic [3:0]      out_index_q, out_index_d;
    logic [2*DW-1:0] mem_q [2][16];

    logic            in_ready;
    logic            wr_en;
    logic            ld_en;
    logic            load;
    logic [DW-1:0]   rd_real;
    logic [DW-1:0]   rd_imag;

    assign in_ready = (state_q[wbank_q] != StFull);
    assign wr_en    = bus.in_valid && in_ready;
    assign ld_en    = !out_valid_q || bus.out_ready;
    assign load     = ld_en && (state_q[rbank_q] == StFull);
    assign {rd_real, rd_imag} = mem_q[rbank_q][bitrev4(rcnt_q)];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_real  = out_real_q;
    assign bus.out_imag  = out_imag_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;

    always_comb begin
        state_d     = state_q;
        wbank_d     = wbank_q;
        wcnt_d      = wcnt_q;
        rbank_d     = rbank_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        out_index_d = out_index_q;

        if (wr_en) begin
            wcnt_d = wcnt_q + 3'd1;
            if (wcnt_q == 3'd7) begin
                state_d[wbank_q] = StFull;
                wbank_d          = !wbank_q;
            end else begin
                state_d[wbank_q] = StFilling;
            end
        end

        if (ld_en) begin
            out_valid_d = load;
        end

        // Release never targets the write bank: in_ready is low while that bank is full.
        if (load) begin
            out_real_d  = scale(rd_real);
            out_imag_d  = scale(rd_imag);
            out_index_d = rcnt_q;
            out_last_d  = (rcnt_q == 4'd15);
            rcnt_d      = rcnt_q + 4'd1;
            if (rcnt_q == 4'd15) begin
                state_d[rbank_q] = StEmpty;
                rbank_d          = !rbank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q[0]  <= StEmpty;
            state_q[1]  <= StEmpty;
            wbank_q     <= 1'b0;
            wcnt_q      <= 3'd0;
            rbank_q     <= 1'b0;
            rcnt_q      <= 4'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_index_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            wbank_q     <= wbank_d;
            wcnt_q      <= wcnt_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            out_index_q <= out_index_d;
        end
    end

    // Storage is not reset; bank state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wbank_q][{wcnt_q, 1'b0}] <= {bus.y0_real, bus.y0_imag};
            mem_q[wbank_q][{wcnt_q, 1'b1}] <= {bus.y1_real, bus.y1_imag};
        end
    end
endmodule

// File: tb/tb_fft16_reorder.sv
// Randomized bench for fft16_reorder: frames are built in natural order and fed bit-reversed.
// Build with FFT16_REORDER_SCALE_EN on both bench and RTL to exercise the scaled outputs.
module tb_fft16_reorder;
    localparam int unsigned DW = 24;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [3:0]    idx;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft16_reorder_if #(.DW(DW)) bus ();

    fft16_reorder #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] fr_re [16];
    logic [DW-1:0] fr_im [16];
    int            ready_mode = 0;
    int            pairs_acc = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] bitrev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [DW-1:0] model_out(input logic [DW-1:0] x);
`ifdef FFT16_REORDER_SCALE_EN
        longint v;
        v = $signed(x);
        v = (v + 8) >>> 4;
        return v[DW-1:0];
`else
        return x;
`endif
    endfunction

    task automatic gen_ramp();
        for (int k = 0; k < 16; k++) begin
            fr_re[k] = DW'(k);
            fr_im[k] = DW'(-k);
        end
    endtask

    task automatic gen_random();
        for (int k = 0; k < 16; k++) begin
            fr_re[k] = DW'($urandom);
            fr_im[k] = DW'($urandom);
        end
    endtask

    // Sends pairs of the current frame; a full frame is queued as expected output once accepted.
    task automatic send_frame(input int gap_max, input int npairs);
        for (int p = 0; p < npairs; p++) begin
            int gaps;
            bit acc;
            int budget;
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            bus.in_valid = 1'b0;
            repeat (gaps) begin
                @(posedge clk);
                #1;
            end
            bus.y0_real  = fr_re[bitrev4(4'(2 * p))];
            bus.y0_imag  = fr_im[bitrev4(4'(2 * p))];
            bus.y1_real  = fr_re[bitrev4(4'(2 * p + 1))];
            bus.y1_imag  = fr_im[bitrev4(4'(2 * p + 1))];
            bus.in_valid = 1'b1;
            acc    = 1'b0;
            budget = 0;
            while (!acc) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                budget++;
                if (!acc && budget > 2000) begin
                    check_eq("accept_timeout", 64'(bus.in_ready), 64'd1);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
            pairs_acc++;
        end
        bus.in_valid = 1'b0;
        if (npairs == 8) begin
            for (int k = 0; k < 16; k++) begin
                exp_q.push_back('{re: model_out(fr_re[k]), im: model_out(fr_im[k]),
                                  idx: 4'(k), last: (k == 15)});
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_idle"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset right now, checks reset values, then releases away from the clock edges.
    task automatic pulse_reset(input string tag);
        #1;
        rst = 1'b0;
        #1;
        check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_real"}, 64'(bus.out_real), 64'd0);
        check_eq({tag, "_imag"}, 64'(bus.out_imag), 64'd0);
        check_eq({tag, "_index"}, 64'(bus.out_index), 64'd0);
        check_eq({tag, "_last"}, 64'(bus.out_last), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Sink: out_ready changes just after the rising edge.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                2:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Every valid output must match the queue head; it is consumed only on a handshake.
    always @(negedge clk) begin
        if (rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                check_eq("out_real", 64'(bus.out_real), 64'(exp_q[0].re));
                check_eq("out_imag", 64'(bus.out_imag), 64'(exp_q[0].im));
                check_eq("out_index", 64'(bus.out_index), 64'(exp_q[0].idx));
                check_eq("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.y0_real  = '0;
        bus.y0_imag  = '0;
        bus.y1_real  = '0;
        bus.y1_imag  = '0;
        ready_mode   = 0;
        #3;
        pulse_reset("reset");

        // Ramp frame at full rate: value equals bin number, latency of one cycle.
        gen_ramp();
        send_frame(0, 8);
        @(negedge clk);
        check_eq("lat_edge_t", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_edge_t1", 64'(bus.out_valid), 64'd1);
        check_eq("lat_index0", 64'(bus.out_index), 64'd0);
        wait_drain("single");

        // Alternating back-pressure on the same frame.
        ready_mode = 2;
        send_frame(0, 8);
        wait_drain("bp");

        // Idle gaps between input pairs.
        ready_mode = 0;
        send_frame(4, 8);
        wait_drain("gaps");

        // Both banks fill with the sink stalled; third frame waits for bank 0 release.
        ready_mode = 1;
        pairs_acc  = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    gen_random();
                    send_frame(0, 8);
                end
            end
            begin
                int t;
                t = 0;
                while (pairs_acc < 16 && t < 200) begin
                    @(posedge clk);
                    t++;
                end
                repeat (4) @(posedge clk);
                @(negedge clk);
                check_eq("ovf_in_ready", 64'(bus.in_ready), 64'd0);
                check_eq("ovf_pairs", 64'(pairs_acc), 64'd16);
                ready_mode = 0;
                t = 0;
                while (!(bus.out_valid && bus.out_index == 4'd14) && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("ovf_ready_bin14", 64'(bus.in_ready), 64'd0);
                @(negedge clk);
                check_eq("ovf_index15", 64'(bus.out_index), 64'd15);
                check_eq("ovf_ready_bin15", 64'(bus.in_ready), 64'd1);
            end
        join
        wait_drain("ovf");

        // Reset with a partial frame, then reset while bin 6 is on the output.
        gen_random();
        send_frame(0, 5);
        pulse_reset("rst_partial");
        gen_random();
        send_frame(0, 8);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!(bus.out_valid && bus.out_index == 4'd6) && t < 100) begin
                @(negedge clk);
                t++;
            end
            check_eq("rst_bin6_seen", 64'(bus.out_index), 64'd6);
        end
        pulse_reset("rst_bin6");
        gen_ramp();
        send_frame(2, 8);
        wait_drain("post_rst");

        // Scaling corner values (identity in the default build).
        gen_random();
        fr_re[0] = 24'h000017;
        fr_re[1] = 24'hFFFFE8;
        fr_re[2] = 24'h7FFFFF;
        fr_im[3] = 24'h800000;
        send_frame(0, 8);
        wait_drain("scale");

        // Random traffic with random sink stalls.
        ready_mode = 3;
        for (int f = 0; f < 6; f++) begin
            gen_random();
            send_frame(f % 3, 8);
        end
        ready_mode = 0;
        wait_drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fft16_reorder.md
# fft16_reorder

Output reorder buffer for the 16-point radix-2 FFT. It sits directly downstream of the final butterfly stage. Each cycle it accepts one butterfly result pair (y0, y1) in the pipeline's bit-reversed order. It stores a full 16-bin frame in a ping-pong buffer and streams the bins out in natural order 0..15, one complex sample per cycle, with a valid/ready handshake.

## Interface
- `DW`, 24: sample width, two's complement, matching butterfly output width.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: pair on `y*` is valid.
- `in_ready` output 1: buffer can accept a pair this cycle.
- `y0_real`, `y0_imag` input DW: first butterfly output of the pair.
- `y1_real`, `y1_imag` input DW: second butterfly output of the pair.
- `out_valid` output 1: output sample valid.
- `out_ready` input 1: downstream accepts the sample.
- `out_real`, `out_imag` output DW: bin value.
- `out_index` output 4: bin number k of the current sample.
- `out_last` output 1: high with k = 15.

## Operation
- Storage: two banks B0 and B1, each holding 16 entries of {real, imag}. Each bank state is EMPTY, FILLING or FULL. A bank being drained is FULL until it is released.
- Write side:
  - `wbank` (reset 0) selects the bank, `wcnt` (0..7, reset 0) counts pairs.
  - `in_ready` = (state[wbank] != FULL), so it reads 1 out of reset.
  - Accept on `in_valid && in_ready`: pair number `wcnt` = p writes y0 to address 2p and y1 to address 2p+1. The bank goes EMPTY→FILLING on the first accepted pair.
  - On the accept with `wcnt` = 7: the bank goes to FULL, `wcnt` → 0, `wbank` toggles.
- Address rule: storage address a holds bin bitrev4(a), where bitrev4(b3b2b1b0) = b0b1b2b3.
- Read side:
  - `rbank` (reset 0) selects the bank, `rcnt` (0..15, reset 0) counts bins.
  - The output register loads when `out_valid == 0 || out_ready == 1`, and only if state[rbank] == FULL.
  - On load: `out_real`/`out_imag` = bank[rbank][bitrev4(rcnt)], `out_index` = `rcnt`, `out_last` = (`rcnt` == 15), then `rcnt` increments.
  - If the output register would load but state[rbank] != FULL, it clears `out_valid`.
  - Loading with `rcnt` == 15 releases the bank: state → EMPTY, `rcnt` → 0, `rbank` toggles.
- Simultaneous events:
  - A release of one bank and a write into the other in the same cycle are independent.
  - A release and a write can never hit the same bank in one cycle, because `in_ready` is 0 while that bank is FULL.
  - A write to a bank freed at edge T is accepted from edge T+1.
- Input values are stored unmodified, with no arithmetic, unless the scaling macro below is enabled.
- `in_valid` while `in_ready` is 0: the pair is ignored, and the source must hold it.
- Reset mid-operation clears all bank states to EMPTY, clears all pointers, and drops `out_valid`. Partial frames are discarded. Memory contents need not be cleared.

## Timing
- Reset values: `out_valid` = 0, `out_real` = `out_imag` = 0, `out_index` = 0, `out_last` = 0, `in_ready` = 1.
- Latency: if the 8th pair is accepted at edge T, the output loads bin 0 at edge T+1, so `out_valid` is high after T+1.
- Throughput, write side: 8 cycles per frame.
- Throughput, read side: 16 cycles per frame at `out_ready` = 1, with no bubbles between consecutive FULL banks.
- Sustained input of more than 1 pair per 2 cycles eventually fills both banks, and `in_ready` then drops until B0 is released.
- `out_*` hold stable while `out_valid && !out_ready`.
- The FSM per bank is: EMPTY --first write--> FILLING --8th write--> FULL --bin 15 loaded--> EMPTY.

## Configuration
- `FFT16_REORDER_SCALE_EN` defined:
  - Outputs are divided by N = 16 with rounding: out = (x + 8) >>> 4, computed in DW+1 bits and sign-extended back to DW.
  - This cannot overflow.
  - Applied at output register load; latency is unchanged.
- Not defined: outputs equal stored values bit-exactly.

## Test plan
- Single frame, `out_ready` = 1: pair p with y0_real = bitrev4(2p), y1_real = bitrev4(2p+1), imag = −real → 16 consecutive outputs with out_real = `out_index` = 0..15, out_imag = −k, and `out_last` only at k = 15. `out_valid` rises the cycle after the 8th accept.
- Back-pressure: toggle `out_ready` 1/0 every cycle in the same frame → each bin appears exactly once, in order, and values hold while stalled.
- Overflow stall: send 3 frames back-to-back at `in_valid` = 1 with `out_ready` = 0 → `in_ready` = 0 after 16 pairs. Then raise `out_ready` → frame 1 comes out, `in_ready` returns 1 the cycle after frame-1 bin 15 loads, and frames 2 and 3 come out intact and in order.
- Reset mid-operation: assert `rst` after 5 pairs and during readout of bin 6 → all outputs go to reset values immediately. A following clean frame comes out correctly from bin 0.
- Invalid gaps: insert `in_valid` = 0 gaps between pairs → same output as the single-frame test.
- With `FFT16_REORDER_SCALE_EN`: inputs 0x000017, 0xFFFFE8 (−24), 0x7FFFFF → outputs 0x000001, 0xFFFFFF (−1), 0x080000.
